// File: rtl/hci_core_demux_addr.sv
`default_nettype none

// ============================================================================
//  Module   : hci_package
//  Purpose  : Default widths shared by the HCI core bundle.
//  Revision : 1.0  initial release
// ============================================================================
package hci_package;
    localparam int unsigned DEFAULT_DW = 32;   // data width
    localparam int unsigned DEFAULT_AW = 32;   // address width
    localparam int unsigned DEFAULT_BW = 8;    // byte width
    localparam int unsigned DEFAULT_WW = 32;   // word width
endpackage

// ============================================================================
//  Interface : hci_core_intf
//  Purpose   : HCI core request/response bundle.
//              master : drives req/add/wen/data/be/boffs/lrdy,
//                       receives gnt/r_data/r_valid/r_opc
//              slave  : mirror image of master
//  Revision  : 1.0  initial release
// ============================================================================
interface hci_core_intf #(
    parameter int unsigned DW = hci_package::DEFAULT_DW,
    parameter int unsigned AW = hci_package::DEFAULT_AW,
    parameter int unsigned BW = hci_package::DEFAULT_BW,
    parameter int unsigned WW = hci_package::DEFAULT_WW,
    parameter int unsigned OW = 1
) ();
    // One byte-offset field of OW bits per word carried on the data bus.
    localparam int unsigned c_nw = ((DW / WW) > 0) ? (DW / WW) : 1;

    logic                  req;
    logic                  gnt;
    logic [AW-1:0]         add;
    logic                  wen;
    logic [DW-1:0]         data;
    logic [DW/BW-1:0]      be;
    logic [c_nw*OW-1:0]    boffs;
    logic                  lrdy;
    logic [DW-1:0]         r_data;
    logic                  r_valid;
    logic                  r_opc;

    modport master (
        output req, add, wen, data, be, boffs, lrdy,
        input  gnt, r_data, r_valid, r_opc
    );

    modport slave (
        input  req, add, wen, data, be, boffs, lrdy,
        output gnt, r_data, r_valid, r_opc
    );
endinterface

// ============================================================================
//  Module   : hci_core_demux_addr
//  Purpose  : Address-decoded 1-to-N HCI demultiplexer. The target is picked
//             from a field of the request address. Several transactions may
//             be outstanding, but only towards one target at a time, so the
//             responses come back in order from a single known channel.
//  Ports    : clk_i    - clock
//             rst_ni   - asynchronous active-low reset
//             clear_i  - synchronous clear of the outstanding-tracking state
//             in       - initiator-side channel (slave modport)
//             out[N]   - target-side channels (master modport)
//  Revision : 1.0  initial release
// ============================================================================
module hci_core_demux_addr #(
    parameter int unsigned NB_OUT_CHAN     = 2,
    parameter int unsigned DW              = hci_package::DEFAULT_DW,
    parameter int unsigned AW              = hci_package::DEFAULT_AW,
    parameter int unsigned BW              = hci_package::DEFAULT_BW,
    parameter int unsigned WW              = hci_package::DEFAULT_WW,
    parameter int unsigned OW              = 1,
    parameter int unsigned ADDR_SEL_LSB    = 2,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    hci_core_intf.slave  in,
    hci_core_intf.master out [NB_OUT_CHAN-1:0]
);

    localparam int unsigned c_sel_w = (NB_OUT_CHAN > 1) ? $clog2(NB_OUT_CHAN) : 1;
    localparam int unsigned c_cnt_w = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned c_nw    = ((DW / WW) > 0) ? (DW / WW) : 1;

    localparam logic [c_cnt_w-1:0] c_cnt_max  = c_cnt_w'(MAX_OUTSTANDING);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_zero = '0;

    // ------------------------------------------------------------------
    // Tracking state
    // ------------------------------------------------------------------
    logic [c_cnt_w-1:0] r_cnt;      // granted but not yet answered
    logic [c_sel_w-1:0] r_cur_q;    // target owning the outstanding traffic

    // ------------------------------------------------------------------
    // Per-channel views of the target-side inputs, so they can be
    // indexed by a run-time channel number.
    // ------------------------------------------------------------------
    logic [NB_OUT_CHAN-1:0] w_gnt;
    logic [NB_OUT_CHAN-1:0] w_rvalid;
    logic [NB_OUT_CHAN-1:0] w_ropc;
    logic [DW-1:0]          w_rdata [NB_OUT_CHAN];

    // Request payload broadcast to every target unmodified.
    logic [AW-1:0]          w_add;
    logic                   w_wen;
    logic [DW-1:0]          w_data;
    logic [DW/BW-1:0]       w_be;
    logic [c_nw*OW-1:0]     w_boffs;
    logic                   w_lrdy;

    logic [c_sel_w-1:0]     w_sel;
    logic                   w_busy;
    logic                   w_allowed;
    logic                   w_req_ok;
    logic                   w_gnt_in;
    logic                   w_accept;
    logic                   w_rvalid_in;
    logic                   w_stray;

    assign w_add   = in.add;
    assign w_wen   = in.wen;
    assign w_data  = in.data;
    assign w_be    = in.be;
    assign w_boffs = in.boffs;
    assign w_lrdy  = in.lrdy;

    assign w_sel  = w_add[ADDR_SEL_LSB +: c_sel_w];
    assign w_busy = (r_cnt != c_cnt_zero);

    // Only the registered count decides admission, so a response arriving
    // in the same cycle never opens the gate for a new target early.
    assign w_allowed = !w_busy || ((w_sel == r_cur_q) && (r_cnt < c_cnt_max));

    // rst_ni gates the request path directly: while reset is asserted no
    // request may leak to a target, independent of the clock.
    assign w_req_ok = in.req && w_allowed && rst_ni;

    assign w_gnt_in = w_req_ok && w_gnt[w_sel];
    assign w_accept = in.req && w_gnt_in;

    assign in.gnt = w_gnt_in;

    // ------------------------------------------------------------------
    // Target-side fan-out / fan-in
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < NB_OUT_CHAN; k++) begin : g_chan
            assign out[k].req   = w_req_ok && (w_sel == c_sel_w'(k));
            assign out[k].add   = w_add;
            assign out[k].wen   = w_wen;
            assign out[k].data  = w_data;
            assign out[k].be    = w_be;
            assign out[k].boffs = w_boffs;
            assign out[k].lrdy  = w_lrdy;

            assign w_gnt[k]    = out[k].gnt;
            assign w_rvalid[k] = out[k].r_valid;
            assign w_ropc[k]   = out[k].r_opc;
            assign w_rdata[k]  = out[k].r_data;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Response path: only the owning target is listened to, and nothing
    // at all while no transaction is outstanding.
    // ------------------------------------------------------------------
    assign w_rvalid_in = w_rvalid[r_cur_q] && w_busy;

    assign in.r_valid = w_rvalid_in;
    assign in.r_data  = w_busy ? w_rdata[r_cur_q] : '0;
    assign in.r_opc   = w_busy ? w_ropc[r_cur_q]  : 1'b0;

    // ------------------------------------------------------------------
    // Outstanding counter and current-target register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt   <= '0;
            r_cur_q <= '0;
        end else if (clear_i) begin
            r_cnt   <= '0;
            r_cur_q <= '0;
        end else begin
            // Accept and response together leave the count unchanged.
            // The bounds guards keep the counter inside 0..MAX even if the
            // admission logic were ever bypassed.
            if (w_accept && !w_rvalid_in && (r_cnt < c_cnt_max)) begin
                r_cnt <= r_cnt + c_cnt_one;
            end else if (!w_accept && w_rvalid_in && w_busy) begin
                r_cnt <= r_cnt - c_cnt_one;
            end
            if (w_accept) begin
                r_cur_q <= w_sel;
            end
        end
    end

    // ------------------------------------------------------------------
    // A response from a channel that does not own the outstanding traffic
    // (or with nothing outstanding) is dropped; flag it in simulation.
    // ------------------------------------------------------------------
    always_comb begin
        w_stray = 1'b0;
        for (int k = 0; k < NB_OUT_CHAN; k++) begin
            if (w_rvalid[k] && (!w_busy || (r_cur_q != c_sel_w'(k)))) begin
                w_stray = 1'b1;
            end
        end
    end

    a_no_stray_rvalid : assert property (
        @(posedge clk_i) disable iff (!rst_ni) !w_stray
    ) else $warning("hci_core_demux_addr: r_valid from a non-owning channel ignored");

endmodule

`default_nettype wire

// File: tb/tb_hci_core_demux_addr.sv
`default_nettype none

// ============================================================================
//  Module   : tb_hci_core_demux_addr
//  Purpose  : Self-checking bench for hci_core_demux_addr. Directed cases
//             for the key corner behaviours, followed by random traffic
//             compared against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hci_core_demux_addr;

    localparam int NB   = 2;
    localparam int MAXO = 4;
    localparam int LSB  = 2;
    localparam int DW   = 32;
    localparam int AW   = 32;
    localparam int BW   = 8;
    localparam int WW   = 32;
    localparam int OW   = 1;
    localparam int SW   = $clog2(NB);

    logic clk_i = 1'b0;
    logic rst_ni;
    logic clear_i;

    always #5 clk_i = ~clk_i;

    hci_core_intf #(.DW(DW), .AW(AW), .BW(BW), .WW(WW), .OW(OW)) in_if ();
    hci_core_intf #(.DW(DW), .AW(AW), .BW(BW), .WW(WW), .OW(OW)) out_if [NB-1:0] ();

    hci_core_demux_addr #(
        .NB_OUT_CHAN     (NB),
        .DW              (DW),
        .AW              (AW),
        .BW              (BW),
        .WW              (WW),
        .OW              (OW),
        .ADDR_SEL_LSB    (LSB),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .in      (in_if),
        .out     (out_if)
    );

    // Target-side stimulus and observation
    logic [NB-1:0] tb_gnt;
    logic [NB-1:0] tb_rvalid;
    logic [NB-1:0] tb_ropc;
    logic [DW-1:0] tb_rdata [NB];
    logic [NB-1:0] obs_req;
    logic [AW-1:0] obs_add  [NB];
    logic [DW-1:0] obs_data [NB];

    generate
        for (genvar k = 0; k < NB; k++) begin : g_tap
            assign out_if[k].gnt     = tb_gnt[k];
            assign out_if[k].r_valid = tb_rvalid[k];
            assign out_if[k].r_opc   = tb_ropc[k];
            assign out_if[k].r_data  = tb_rdata[k];
            assign obs_req[k]        = out_if[k].req;
            assign obs_add[k]        = out_if[k].add;
            assign obs_data[k]       = out_if[k].data;
        end
    endgenerate

    int n_err = 0;
    int n_chk = 0;

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        in_if.req   = 1'b0;
        in_if.add   = '0;
        in_if.wen   = 1'b1;
        in_if.data  = '0;
        in_if.be    = '1;
        in_if.boffs = '0;
        in_if.lrdy  = 1'b1;
        tb_gnt      = '0;
        tb_rvalid   = '0;
        tb_ropc     = '0;
        for (int k = 0; k < NB; k++) tb_rdata[k] = '0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        in_if.req = 1'b1;
        in_if.add = a;
        in_if.wen = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: a queue holding the target of every transaction
    // granted but not yet answered, plus the target last granted.
    // ------------------------------------------------------------------
    int m_q[$];
    int m_cur;

    function automatic bit m_allowed(input int sel);
        return (m_q.size() == 0) || ((sel == m_cur) && (m_q.size() < MAXO));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_ni  = 1'b0;
        clear_i = 1'b0;
        idle();

        // ---------------- reset state, request held high ----------------
        rd(32'h04);
        tb_gnt = '1;
        #12;
        chk_eq("rst_req0", obs_req[0], 0);
        chk_eq("rst_req1", obs_req[1], 0);
        chk_eq("rst_gnt", in_if.gnt, 0);
        chk_eq("rst_rvalid", in_if.r_valid, 0);
        chk_eq("rst_cnt", dut.r_cnt, 0);
        chk_eq("rst_cur", dut.r_cur_q, 0);
        tick();
        rst_ni = 1'b1;
        idle();
        tick();

        // ---------------- single read to target 1 -----------------------
        rd(32'h04);
        tb_gnt = 2'b10;
        #1;
        chk_eq("t1_req1", obs_req[1], 1);
        chk_eq("t1_req0", obs_req[0], 0);
        chk_eq("t1_gnt", in_if.gnt, 1);
        tick();
        chk_eq("t1_cnt", dut.r_cnt, 1);
        chk_eq("t1_cur", dut.r_cur_q, 1);
        idle();
        tb_rvalid[1] = 1'b1;
        tb_rdata[1]  = 32'hCAFE;
        #1;
        chk_eq("t1_rvalid", in_if.r_valid, 1);
        chk_eq("t1_rdata", in_if.r_data, 32'hCAFE);
        tick();
        chk_eq("t1_cnt_done", dut.r_cnt, 0);
        idle();

        // ---------------- different target stalls -----------------------
        rd(32'h04);
        tb_gnt = '1;
        #1;
        chk_eq("t2_gnt_first", in_if.gnt, 1);
        tick();
        chk_eq("t2_cnt1", dut.r_cnt, 1);
        rd(32'h00);
        #1;
        chk_eq("t2_stall_gnt", in_if.gnt, 0);
        chk_eq("t2_stall_req0", obs_req[0], 0);
        tick();
        #1;
        chk_eq("t2_stall_gnt2", in_if.gnt, 0);
        tb_rvalid[1] = 1'b1;
        #1;
        chk_eq("t2_resp_gnt", in_if.gnt, 0);
        chk_eq("t2_resp_rvalid", in_if.r_valid, 1);
        tick();
        chk_eq("t2_cnt0", dut.r_cnt, 0);
        tb_rvalid = '0;
        #1;
        chk_eq("t2_issue_gnt", in_if.gnt, 1);
        chk_eq("t2_issue_req0", obs_req[0], 1);
        tick();
        chk_eq("t2_cnt_new", dut.r_cnt, 1);
        chk_eq("t2_cur_new", dut.r_cur_q, 0);
        in_if.req    = 1'b0;
        tb_rvalid[0] = 1'b1;
        tick();
        tb_rvalid = '0;
        chk_eq("t2_drain", dut.r_cnt, 0);

        // ---------------- fill to MAX_OUTSTANDING -----------------------
        rd(32'h08);
        tb_gnt = '1;
        for (int i = 0; i < MAXO; i++) begin
            #1;
            chk_eq("t3_fill_gnt", in_if.gnt, 1);
            tick();
        end
        chk_eq("t3_cnt_max", dut.r_cnt, MAXO);
        #1;
        chk_eq("t3_full_gnt", in_if.gnt, 0);
        chk_eq("t3_full_req0", obs_req[0], 0);
        tick();
        chk_eq("t3_cnt_hold", dut.r_cnt, MAXO);
        tb_rvalid[0] = 1'b1;
        #1;
        chk_eq("t3_resp_gnt", in_if.gnt, 0);
        chk_eq("t3_resp_rvalid", in_if.r_valid, 1);
        tick();
        chk_eq("t3_cnt_dec", dut.r_cnt, MAXO - 1);
        tb_rvalid = '0;
        #1;
        chk_eq("t3_fifth_gnt", in_if.gnt, 1);
        tick();
        chk_eq("t3_cnt_refill", dut.r_cnt, MAXO);
        in_if.req    = 1'b0;
        tb_rvalid[0] = 1'b1;
        repeat (MAXO) tick();
        tb_rvalid = '0;
        chk_eq("t3_drain", dut.r_cnt, 0);

        // ---------------- accept and response together ------------------
        rd(32'h08);
        tick();
        tick();
        chk_eq("t4_cnt2", dut.r_cnt, 2);
        tb_rvalid[0] = 1'b1;
        #1;
        chk_eq("t4_gnt", in_if.gnt, 1);
        chk_eq("t4_rvalid", in_if.r_valid, 1);
        tick();
        chk_eq("t4_cnt_same", dut.r_cnt, 2);
        in_if.req = 1'b0;
        tick();
        tick();
        tb_rvalid = '0;
        chk_eq("t4_drain", dut.r_cnt, 0);

        // ---------------- clear with traffic in flight ------------------
        rd(32'h04);
        repeat (3) tick();
        chk_eq("t5_cnt3", dut.r_cnt, 3);
        chk_eq("t5_cur1", dut.r_cur_q, 1);
        in_if.req = 1'b0;
        clear_i   = 1'b1;
        tick();
        clear_i = 1'b0;
        chk_eq("t5_clr_cnt", dut.r_cnt, 0);
        chk_eq("t5_clr_cur", dut.r_cur_q, 0);
        tb_rvalid[1] = 1'b1;
        tb_rdata[1]  = 32'h1234;
        #1;
        chk_eq("t5_late_rvalid", in_if.r_valid, 0);
        chk_eq("t5_late_rdata", in_if.r_data, 0);
        chk_eq("t5_stray_flag", dut.w_stray, 1);
        tick();
        tb_rvalid = '0;
        tick();

        // ---------------- asynchronous reset mid-burst ------------------
        rd(32'h04);
        tick();
        tick();
        chk_eq("t6_cnt2", dut.r_cnt, 2);
        tb_rvalid[1] = 1'b1;
        #1;
        chk_eq("t6_pre_rvalid", in_if.r_valid, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk_eq("t6_req0", obs_req[0], 0);
        chk_eq("t6_req1", obs_req[1], 0);
        chk_eq("t6_gnt", in_if.gnt, 0);
        chk_eq("t6_rvalid", in_if.r_valid, 0);
        chk_eq("t6_cnt", dut.r_cnt, 0);
        idle();
        tick();
        rst_ni = 1'b1;
        tick();

        // ---------------- random traffic against the model --------------
        m_q.delete();
        m_cur = 0;
        for (int c = 0; c < 1500; c++) begin
            int            sel;
            bit            clr;
            bit            acc;
            bit            resp;
            logic [AW-1:0] a;
            logic [DW-1:0] exp_rd;
            bit            exp_ropc;

            if ((m_q.size() > 0) && (($urandom % 4) != 0)) sel = m_cur;
            else                                            sel = int'($urandom % NB);
            a = $urandom;
            a[LSB +: SW] = SW'(sel);
            in_if.req  = (($urandom % 4) != 0);
            in_if.add  = a;
            in_if.wen  = 1'($urandom);
            in_if.data = $urandom;
            in_if.be   = 4'($urandom);
            tb_gnt     = NB'($urandom);
            tb_ropc    = NB'($urandom);
            for (int k = 0; k < NB; k++) tb_rdata[k] = $urandom;
            tb_rvalid = '0;
            if ((m_q.size() > 0) && (($urandom % 2) == 1)) tb_rvalid[m_cur] = 1'b1;
            clr     = (($urandom % 64) == 0);
            clear_i = clr;
            #1;

            acc      = in_if.req && m_allowed(sel) && tb_gnt[sel];
            resp     = (m_q.size() > 0) && tb_rvalid[m_cur];
            exp_rd   = (m_q.size() > 0) ? tb_rdata[m_cur] : '0;
            exp_ropc = (m_q.size() > 0) ? tb_ropc[m_cur] : 1'b0;

            chk_eq("rnd_gnt", in_if.gnt, acc);
            for (int k = 0; k < NB; k++) begin
                chk_eq("rnd_req", obs_req[k], in_if.req && m_allowed(sel) && (sel == k));
                chk_eq("rnd_add", obs_add[k], a);
                chk_eq("rnd_data", obs_data[k], in_if.data);
            end
            chk_eq("rnd_rvalid", in_if.r_valid, resp);
            chk_eq("rnd_rdata", in_if.r_data, exp_rd);
            chk_eq("rnd_ropc", in_if.r_opc, exp_ropc);

            if (clr) begin
                m_q.delete();
                m_cur = 0;
            end else begin
                if (resp) void'(m_q.pop_front());
                if (acc) begin
                    m_q.push_back(sel);
                    m_cur = sel;
                end
            end

            tick();
            chk_eq("rnd_cnt", dut.r_cnt, m_q.size());
            chk_eq("rnd_cur", dut.r_cur_q, m_cur);
        end

        clear_i = 1'b0;
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
